// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared types and constants for the HI/LO multiply/divide
// sequencer.
//   md_op_e     - decoded HI/LO operation encodings (MD_MULT .. MD_MSUB)
//   mdc_state_e - sequencer states (MDC_IDLE .. MDC_COMMIT)
//   hilo_op_e   - how a 64-bit commit combines with the current HI/LO pair
//   ZeroWord    - 32-bit zero
//   WAIT_CNT_W  - width of the shared wait counter, sized to hold the longest
//                 timeout value (40)
// Optional feature macro used by the files importing this package: MADDSUB_EN.
package muldiv_ctrl_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'b000,
    MD_MULTU = 3'b001,
    MD_DIV   = 3'b010,
    MD_DIVU  = 3'b011,
    MD_MTHI  = 3'b100,
    MD_MTLO  = 3'b101,
    MD_MADD  = 3'b110,
    MD_MSUB  = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MDC_IDLE     = 2'd0,
    MDC_MUL_WAIT = 2'd1,
    MDC_DIV_WAIT = 2'd2,
    MDC_COMMIT   = 2'd3
  } mdc_state_e;

  typedef enum logic [1:0] {
    HILO_LOAD = 2'd0,
    HILO_ADD  = 2'd1,
    HILO_SUB  = 2'd2
  } hilo_op_e;

  localparam logic [31:0] ZeroWord   = 32'h0000_0000;
  localparam int          WAIT_CNT_W = 6;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: bundles the EX-stage request, the multiplier/divider
// handshakes and the HI/LO outputs of muldiv_ctrl.
//   slave  modport - the sequencer itself (muldiv_ctrl)
//   master modport - the environment: EX stage, the two units, the HI/LO readers
// Signals: op_valid/op/src_a/src_b/flush (EX request), stall_req, busy,
// mul_* and div_* (unit handshakes), hi/lo, dbg_state (current FSM state).
//
// Handshake: a unit operation starts when *_start is high and ends on the
// single-cycle *_ready pulse; *_start is high only while the sequencer waits
// for that pulse and drops in the very cycle the pulse is seen, so a unit that
// has just completed never sees start again. *_stop is a single-cycle abort
// pulse (flush or timeout), during which *_start is low.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        stall_req;
  logic        mul_start;
  logic        mul_stop;
  logic        mul_signed;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic [63:0] mul_result;
  logic        mul_ready;
  logic        div_start;
  logic        div_stop;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic [63:0] div_result;
  logic        div_ready;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  mdc_state_e  dbg_state;

  modport slave (
    input  op_valid, op, src_a, src_b, flush,
    input  mul_result, mul_ready, div_result, div_ready,
    output stall_req, busy, hi, lo, dbg_state,
    output mul_start, mul_stop, mul_signed, mul_a, mul_b,
    output div_start, div_stop, div_signed, div_a, div_b
  );

  modport master (
    output op_valid, op, src_a, src_b, flush,
    output mul_result, mul_ready, div_result, div_ready,
    input  stall_req, busy, hi, lo, dbg_state,
    input  mul_start, mul_stop, mul_signed, mul_a, mul_b,
    input  div_start, div_stop, div_signed, div_a, div_b
  );

endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// muldiv_ctrl_hilo_reg: the architectural HI/LO register pair.
//   clk, resetn  - clock, asynchronous active-low reset
//   i_we_hi/lo   - single-word write of i_wdata (MTHI/MTLO)
//   i_we64       - 64-bit commit of i_wdata64, combined per i_op64
//   o_hi, o_lo   - register contents
// Macro MADDSUB_EN builds the 64-bit accumulate/subtract path; without it a
// commit always loads i_wdata64 directly.
module muldiv_ctrl_hilo_reg
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_we_hi,
  input  logic        i_we_lo,
  input  logic [31:0] i_wdata,
  input  logic        i_we64,
  input  hilo_op_e    i_op64,
  input  logic [63:0] i_wdata64,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] w_next64;

`ifdef MADDSUB_EN
  // 64-bit wrap-around, so MADD/MSUB carry/borrow across the HI/LO boundary.
  always_comb begin
    w_next64 = i_wdata64;
    case (i_op64)
      HILO_ADD: w_next64 = {r_hi, r_lo} + i_wdata64;
      HILO_SUB: w_next64 = {r_hi, r_lo} - i_wdata64;
      default:  w_next64 = i_wdata64;
    endcase
  end
`else
  logic w_unused_op64;
  assign w_unused_op64 = ^i_op64;
  assign w_next64      = i_wdata64;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_hi <= ZeroWord;
      r_lo <= ZeroWord;
    end else if (i_we64) begin
      r_hi <= w_next64[63:32];
      r_lo <= w_next64[31:0];
    end else begin
      if (i_we_hi) r_hi <= i_wdata;
      if (i_we_lo) r_lo <= i_wdata;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences the shared multi-cycle multiplier and divider for the
// EX stage, stalls the pipeline until the unit answers, and commits the 64-bit
// result into HI/LO.
//   clk, resetn - clock, asynchronous active-low reset
//   bus         - muldiv_ctrl_if.slave (EX request, unit handshakes, HI/LO,
//                 stall_req, busy, dbg_state)
// Parameters: MUL_TIMEOUT / DIV_TIMEOUT - wait cycles before a forced abort.
// Macro MADDSUB_EN: op codes 110/111 become MADD/MSUB; otherwise they are
// no-ops.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int MUL_TIMEOUT = 8,
  parameter int DIV_TIMEOUT = 40
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_ctrl_if.slave bus
);

  mdc_state_e            r_state, w_state_nxt;
  md_op_e                r_op, w_op;
  logic [31:0]           r_mul_a, r_mul_b, r_div_a, r_div_b;
  logic                  r_mul_signed, r_div_signed;
  logic [63:0]           r_result;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic                  w_issue_mul, w_issue_div, w_we_hi, w_we_lo, w_capture;
  logic                  w_stall, w_mul_start, w_mul_stop, w_div_start, w_div_stop;
  logic                  w_mul_timeout, w_div_timeout;
  hilo_op_e              w_commit_op;

  assign w_op          = md_op_e'(bus.op);
  assign w_mul_timeout = (r_wait_cnt == WAIT_CNT_W'(MUL_TIMEOUT));
  assign w_div_timeout = (r_wait_cnt == WAIT_CNT_W'(DIV_TIMEOUT));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= MDC_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Priority inside a wait state: flush (a ready pulse in the same cycle is
  // dropped), then ready, then timeout. Start is high only in the plain
  // waiting branch, so it falls in the ready, flush and timeout cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_mul = 1'b0;
    w_issue_div = 1'b0;
    w_we_hi     = 1'b0;
    w_we_lo     = 1'b0;
    w_capture   = 1'b0;
    w_stall     = 1'b0;
    w_mul_start = 1'b0;
    w_mul_stop  = 1'b0;
    w_div_start = 1'b0;
    w_div_stop  = 1'b0;
    unique case (r_state)
      MDC_IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          case (w_op)
            MD_MULT, MD_MULTU: w_issue_mul = 1'b1;
`ifdef MADDSUB_EN
            MD_MADD, MD_MSUB:  w_issue_mul = 1'b1;
`endif
            MD_DIV, MD_DIVU:   w_issue_div = 1'b1;
            MD_MTHI:           w_we_hi     = 1'b1;
            MD_MTLO:           w_we_lo     = 1'b1;
            default:           ;
          endcase
        end
        // Stall already in the issue cycle so the pipeline holds from here.
        if (w_issue_mul) begin
          w_stall     = 1'b1;
          w_state_nxt = MDC_MUL_WAIT;
        end
        if (w_issue_div) begin
          w_stall     = 1'b1;
          w_state_nxt = MDC_DIV_WAIT;
        end
      end
      MDC_MUL_WAIT: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_stall     = 1'b0;
          w_mul_stop  = 1'b1;
          w_state_nxt = MDC_IDLE;
        end else if (bus.mul_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = MDC_COMMIT;
        end else if (w_mul_timeout) begin
          w_mul_stop  = 1'b1;
          w_state_nxt = MDC_IDLE;
        end else begin
          w_mul_start = 1'b1;
        end
      end
      MDC_DIV_WAIT: begin
        w_stall = 1'b1;
        if (bus.flush) begin
          w_stall     = 1'b0;
          w_div_stop  = 1'b1;
          w_state_nxt = MDC_IDLE;
        end else if (bus.div_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = MDC_COMMIT;
        end else if (w_div_timeout) begin
          w_div_stop  = 1'b1;
          w_state_nxt = MDC_IDLE;
        end else begin
          w_div_start = 1'b1;
        end
      end
      // The instruction has retired past EX: commit even under flush.
      MDC_COMMIT: w_state_nxt = MDC_IDLE;
      default:    w_state_nxt = MDC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_op         <= MD_MULT;
      r_mul_a      <= ZeroWord;
      r_mul_b      <= ZeroWord;
      r_mul_signed <= 1'b0;
      r_div_a      <= ZeroWord;
      r_div_b      <= ZeroWord;
      r_div_signed <= 1'b0;
      r_result     <= 64'h0;
      r_wait_cnt   <= '0;
    end else begin
      if (w_issue_mul) begin
        r_op         <= w_op;
        r_mul_a      <= bus.src_a;
        r_mul_b      <= bus.src_b;
        r_mul_signed <= (w_op != MD_MULTU);  // MULT, MADD, MSUB are signed
      end
      if (w_issue_div) begin
        r_op         <= w_op;
        r_div_a      <= bus.src_a;
        r_div_b      <= bus.src_b;
        r_div_signed <= (w_op == MD_DIV);
      end
      if (w_issue_mul || w_issue_div)
        r_wait_cnt <= '0;
      else if (r_state == MDC_MUL_WAIT || r_state == MDC_DIV_WAIT)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      // The divider returns {remainder, quotient}, which already is {HI, LO}.
      if (w_capture)
        r_result <= (r_state == MDC_MUL_WAIT) ? bus.mul_result : bus.div_result;
    end
  end

  always_comb begin
    w_commit_op = HILO_LOAD;
    case (r_op)
      MD_MADD: w_commit_op = HILO_ADD;
      MD_MSUB: w_commit_op = HILO_SUB;
      default: w_commit_op = HILO_LOAD;
    endcase
  end

  muldiv_ctrl_hilo_reg u_hilo (
    .clk       (clk),
    .resetn    (resetn),
    .i_we_hi   (w_we_hi),
    .i_we_lo   (w_we_lo),
    .i_wdata   (bus.src_a),
    .i_we64    (r_state == MDC_COMMIT),
    .i_op64    (w_commit_op),
    .i_wdata64 (r_result),
    .o_hi      (bus.hi),
    .o_lo      (bus.lo)
  );

  assign bus.stall_req  = w_stall;
  assign bus.busy       = (r_state != MDC_IDLE);
  assign bus.dbg_state  = r_state;
  assign bus.mul_start  = w_mul_start;
  assign bus.mul_stop   = w_mul_stop;
  assign bus.mul_signed = r_mul_signed;
  assign bus.mul_a      = r_mul_a;
  assign bus.mul_b      = r_mul_b;
  assign bus.div_start  = w_div_start;
  assign bus.div_stop   = w_div_stop;
  assign bus.div_signed = r_div_signed;
  assign bus.div_a      = r_div_a;
  assign bus.div_b      = r_div_b;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: self-checking bench for muldiv_ctrl with behavioural
// multiplier/divider stubs and a HI/LO reference model.
module tb_muldiv_ctrl;

  localparam logic [2:0] OP_MULT = 3'd0, OP_MULTU = 3'd1, OP_DIV  = 3'd2, OP_DIVU = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO  = 3'd5, OP_MADD = 3'd6, OP_MSUB = 3'd7;
  localparam int MUL_TO = 8;
  localparam int DIV_TO = 40;

  logic clk;
  logic resetn;
  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_TIMEOUT(MUL_TO), .DIV_TIMEOUT(DIV_TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;        // reference HI/LO
  logic [63:0] exp_q[$];          // expected {HI, LO} per issued op

  // ---------------- unit behaviour ----------------
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] xa, xb;
    xa = s ? {{32{a[31]}}, a} : {32'h0, a};
    xb = s ? {{32{b[31]}}, b} : {32'h0, b};
    return xa * xb;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint na, nb, q, r;
    if (b == 32'h0) return 64'hDEAD_BEEF_0BAD_F00D;  // stub's divide-by-zero answer
    na = s ? {{32{a[31]}}, a} : {32'h0, a};
    nb = s ? {{32{b[31]}}, b} : {32'h0, b};
    q = na / nb;
    r = na % nb;
    return {r[31:0], q[31:0]};
  endfunction

  // Multiplier stub: ready arrives in the 3rd cycle of start being high.
  bit mul_hang = 1'b0;
  int mul_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mul_ready  <= 1'b0;
      bus.mul_result <= 64'h0;
      mul_cnt        <= 0;
    end else if (bus.mul_ready) begin
      bus.mul_ready <= 1'b0;
      mul_cnt       <= 0;
    end else if (bus.mul_start && !mul_hang) begin
      if (mul_cnt >= 1) begin
        bus.mul_ready  <= 1'b1;
        bus.mul_result <= ref_mul(bus.mul_a, bus.mul_b, bus.mul_signed);
        mul_cnt        <= 0;
      end else mul_cnt <= mul_cnt + 1;
    end else mul_cnt <= 0;
  end

  // Divider stub: ready arrives in the div_lat-th cycle of start being high.
  bit div_hang = 1'b0;
  int div_lat  = 4;
  int div_cnt;
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.div_ready  <= 1'b0;
      bus.div_result <= 64'h0;
      div_cnt        <= 0;
    end else if (bus.div_ready) begin
      bus.div_ready <= 1'b0;
      div_cnt       <= 0;
    end else if (bus.div_start && !div_hang) begin
      if (div_cnt >= div_lat - 2) begin
        bus.div_ready  <= 1'b1;
        bus.div_result <= ref_div(bus.div_a, bus.div_b, bus.div_signed);
        div_cnt        <= 0;
      end else div_cnt <= div_cnt + 1;
    end else div_cnt <= 0;
  end

  // Monitors: stop pulses, and start seen together with its own ready pulse.
  int stop_pulses = 0;
  int overlap_cnt = 0;
  always @(negedge clk) begin
    #2;
    if (resetn) begin
      if (bus.mul_stop || bus.div_stop) stop_pulses++;
      if ((bus.mul_start && bus.mul_ready) || (bus.div_start && bus.div_ready)) overlap_cnt++;
    end
  end

  // ---------------- driver ----------------
  // Presents one op, holds it while stall_req is high (or until an abort stop
  // pulse), then drops op_valid. Returns stall-high and start-high cycle counts.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n_stall, output int n_start);
    bit done;
    bit stop_seen;
    done = 1'b0;
    n_stall = 0;
    n_start = 0;
    @(negedge clk);
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    for (int c = 0; c < 200; c++) begin
      #2;
      if (bus.mul_start || bus.div_start) n_start++;
      stop_seen = bus.mul_stop || bus.div_stop;
      if (!bus.stall_req) begin done = 1'b1; break; end
      n_stall++;
      if (stop_seen) begin done = 1'b1; break; end
      @(negedge clk);
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL op_timeout: op=%0d stall still %b after %0d cycles, want release", op, bus.stall_req, n_stall);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'h0) begin bad++; $display("FAIL reset_hilo: got %h:%h want 0:0", bus.hi, bus.lo); end
    total++; if (bus.stall_req !== 1'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL reset_stall_busy: got %b/%b want 0/0", bus.stall_req, bus.busy); end
    total++; if ({bus.mul_start, bus.mul_stop, bus.div_start, bus.div_stop, bus.mul_signed, bus.div_signed} !== 6'b0)
      begin bad++; $display("FAIL reset_ctl: got %b want 000000", {bus.mul_start, bus.mul_stop, bus.div_start, bus.div_stop, bus.mul_signed, bus.div_signed}); end
    total++; if ({bus.mul_a, bus.mul_b, bus.div_a, bus.div_b} !== 128'h0) begin bad++; $display("FAIL reset_operands: got nonzero want 0"); end
    total++; if (bus.dbg_state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", bus.dbg_state); end
    @(negedge clk);
    resetn = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
  endtask

  task automatic test_mult_signed();
    int ns, nst;
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, ns, nst);
    total++; if (ns !== 4) begin bad++; $display("FAIL mult_stall: got %0d want 4", ns); end
    total++; if (bus.hi !== 32'hFFFF_FFFF || bus.lo !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mult_hilo: got %h:%h want ffffffff:fffffffa", bus.hi, bus.lo); end
    m_hi = 32'hFFFF_FFFF; m_lo = 32'hFFFF_FFFA;
  endtask

  task automatic test_multu();
    int ns, nst;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ns, nst);
    total++; if (bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h0000_0001) begin bad++; $display("FAIL multu_hilo: got %h:%h want fffffffe:00000001", bus.hi, bus.lo); end
    total++; if (nst !== 2) begin bad++; $display("FAIL multu_start_cycles: got %0d want 2", nst); end
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL multu_start_on_ready: got %0d want 0", overlap_cnt); end
    m_hi = 32'hFFFF_FFFE; m_lo = 32'h0000_0001;
  endtask

  task automatic test_div();
    int ns, nst;
    div_lat = 5;
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, ns, nst);
    total++; if (ns !== 6) begin bad++; $display("FAIL div_stall: got %0d want 6", ns); end
    total++; if (bus.hi !== 32'h0000_0001 || bus.lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_hilo: got %h:%h want 00000001:fffffffd", bus.hi, bus.lo); end
    run_op(OP_DIVU, 32'd100, 32'd0, ns, nst);
    total++; if (bus.hi !== 32'hDEAD_BEEF || bus.lo !== 32'h0BAD_F00D) begin bad++; $display("FAIL div_by_zero: got %h:%h want deadbeef:0badf00d", bus.hi, bus.lo); end
    m_hi = 32'hDEAD_BEEF; m_lo = 32'h0BAD_F00D;
  endtask

  task automatic test_flush();
    int ns, nst, stops0;
    stops0 = stop_pulses;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = OP_MULT; bus.src_a = 32'd5; bus.src_b = 32'd6;
    #2;
    total++; if (bus.stall_req !== 1'b1) begin bad++; $display("FAIL flush_issue_stall: got %b want 1", bus.stall_req); end
    @(negedge clk);
    bus.flush = 1'b1;
    #2;
    total++; if (bus.stall_req !== 1'b0 || bus.mul_stop !== 1'b1 || bus.mul_start !== 1'b0)
      begin bad++; $display("FAIL flush_cycle: got stall=%b stop=%b start=%b want 0/1/0", bus.stall_req, bus.mul_stop, bus.mul_start); end
    @(negedge clk);
    bus.flush = 1'b0; bus.op_valid = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (stop_pulses - stops0 !== 1) begin bad++; $display("FAIL flush_stop_pulses: got %0d want 1", stop_pulses - stops0); end
    total++; if (bus.busy !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
      begin bad++; $display("FAIL flush_discard: got busy=%b %h:%h want 0 %h:%h", bus.busy, bus.hi, bus.lo, m_hi, m_lo); end
    run_op(OP_MTLO, 32'h1234, 32'h0, ns, nst);
    total++; if (bus.lo !== 32'h1234 || ns !== 0) begin bad++; $display("FAIL flush_mtlo: got lo=%h stall=%0d want 00001234/0", bus.lo, ns); end
    m_lo = 32'h1234;
    // flush together with op_valid in IDLE issues nothing
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = OP_DIV; bus.flush = 1'b1;
    #2;
    total++; if (bus.stall_req !== 1'b0) begin bad++; $display("FAIL flush_idle_stall: got %b want 0", bus.stall_req); end
    @(negedge clk);
    bus.op_valid = 1'b0; bus.flush = 1'b0;
    #2;
    total++; if (bus.busy !== 1'b0 || bus.div_start !== 1'b0) begin bad++; $display("FAIL flush_idle_issue: got busy=%b start=%b want 0/0", bus.busy, bus.div_start); end
  endtask

  task automatic test_maddsub();
    int ns, nst;
    run_op(OP_MTHI, 32'h0, 32'h0, ns, nst);
    run_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, ns, nst);
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mt_setup: got %h:%h want 00000000:ffffffff", bus.hi, bus.lo); end
    run_op(OP_MADD, 32'd1, 32'd1, ns, nst);
`ifdef MADDSUB_EN
    total++; if (bus.hi !== 32'h1 || bus.lo !== 32'h0 || ns !== 4) begin bad++; $display("FAIL madd: got %h:%h stall=%0d want 00000001:00000000/4", bus.hi, bus.lo, ns); end
    run_op(OP_MSUB, 32'd1, 32'd1, ns, nst);
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'hFFFF_FFFF) begin bad++; $display("FAIL msub: got %h:%h want 00000000:ffffffff", bus.hi, bus.lo); end
`else
    total++; if (bus.hi !== 32'h0 || bus.lo !== 32'hFFFF_FFFF || ns !== 0) begin bad++; $display("FAIL madd_noop: got %h:%h stall=%0d want 00000000:ffffffff/0", bus.hi, bus.lo, ns); end
`endif
    m_hi = 32'h0; m_lo = 32'hFFFF_FFFF;
  endtask

  task automatic test_timeout();
    int ns, nst, stops0;
    stops0 = stop_pulses;
    div_hang = 1'b1;
    run_op(OP_DIV, 32'd9, 32'd3, ns, nst);
    div_hang = 1'b0;
    total++; if (nst !== DIV_TO || ns !== DIV_TO + 2) begin bad++; $display("FAIL div_timeout_cycles: got start=%0d stall=%0d want %0d/%0d", nst, ns, DIV_TO, DIV_TO + 2); end
    #2;
    total++; if (bus.busy !== 1'b0 || bus.stall_req !== 1'b0 || bus.hi !== m_hi || bus.lo !== m_lo)
      begin bad++; $display("FAIL div_timeout_idle: got busy=%b stall=%b %h:%h", bus.busy, bus.stall_req, bus.hi, bus.lo); end
    mul_hang = 1'b1;
    run_op(OP_MULT, 32'd9, 32'd3, ns, nst);
    mul_hang = 1'b0;
    total++; if (nst !== MUL_TO || ns !== MUL_TO + 2) begin bad++; $display("FAIL mul_timeout_cycles: got start=%0d stall=%0d want %0d/%0d", nst, ns, MUL_TO, MUL_TO + 2); end
    total++; if (stop_pulses - stops0 !== 2) begin bad++; $display("FAIL timeout_stop_pulses: got %0d want 2", stop_pulses - stops0); end
  endtask

  task automatic test_random();
    int ns, nst, exp_stall;
    logic [2:0]  op;
    logic [31:0] a, b;
    logic [63:0] exp, got;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
      div_lat = $urandom_range(2, 8);
      exp = {m_hi, m_lo};
      exp_stall = 0;
      case (op)
        OP_MULT:  begin exp = ref_mul(a, b, 1'b1); exp_stall = 4; end
        OP_MULTU: begin exp = ref_mul(a, b, 1'b0); exp_stall = 4; end
        OP_DIV:   begin exp = ref_div(a, b, 1'b1); exp_stall = div_lat + 1; end
        OP_DIVU:  begin exp = ref_div(a, b, 1'b0); exp_stall = div_lat + 1; end
        OP_MTHI:  exp = {a, m_lo};
        OP_MTLO:  exp = {m_hi, a};
`ifdef MADDSUB_EN
        OP_MADD:  begin exp = {m_hi, m_lo} + ref_mul(a, b, 1'b1); exp_stall = 4; end
        OP_MSUB:  begin exp = {m_hi, m_lo} - ref_mul(a, b, 1'b1); exp_stall = 4; end
`endif
        default:  ;
      endcase
      exp_q.push_back(exp);
      run_op(op, a, b, ns, nst);
      exp = exp_q.pop_front();
      got = {bus.hi, bus.lo};
      total++; if (got !== exp) begin bad++; $display("FAIL rand_hilo[%0d] op=%0d: got %h want %h", i, op, got, exp); end
      total++; if (ns !== exp_stall) begin bad++; $display("FAIL rand_stall[%0d] op=%0d: got %0d want %0d", i, op, ns, exp_stall); end
      m_hi = exp[63:32];
      m_lo = exp[31:0];
    end
  endtask

  task automatic test_reset_mid_op();
    int ns, nst;
    run_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0, ns, nst);
    div_lat = 20;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = OP_DIV; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(negedge clk);
    @(negedge clk);
    #2;
    total++; if (bus.busy !== 1'b1 || bus.div_start !== 1'b1) begin bad++; $display("FAIL midreset_busy: got busy=%b start=%b want 1/1", bus.busy, bus.div_start); end
    resetn = 1'b0;
    bus.op_valid = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.div_start !== 1'b0 || bus.stall_req !== 1'b0 || bus.div_a !== 32'h0 || bus.hi !== 32'h0)
      begin bad++; $display("FAIL midreset_values: got busy=%b start=%b stall=%b div_a=%h hi=%h want all 0", bus.busy, bus.div_start, bus.stall_req, bus.div_a, bus.hi); end
    @(negedge clk);
    resetn = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    div_lat = 4;
  endtask

  // ---------------- sequence / final report ----------------
  initial begin
    resetn = 1'b0;
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.src_a = 32'h0; bus.src_b = 32'h0; bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_mult_signed();
    test_multu();
    test_div();
    test_flush();
    test_maddsub();
    test_timeout();
    test_random();
    test_reset_mid_op();
    test_mult_signed();
    total++; if (overlap_cnt !== 0) begin bad++; $display("FAIL start_with_ready: got %0d want 0", overlap_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
